// File: rtl/latch_bank_wr_ctrl_if.sv
// Write port bundle between requesters and the latch-bank write controller.
//   req   : one write request bit per requester
//   addr  : per-requester word address, requester k at [k*AW +: AW]
//   wdata : per-requester write data, requester k at [k*W +: W]
//   gnt   : one-hot owner of the write in flight
//   ack   : one-cycle completion pulse to the owner
//   err   : pulses with ack when the address was out of range
//   ld    : data presented to the D input of every latch cell
//   len   : one-hot latch enables, one per word
//   busy  : controller is not idle
interface latch_bank_wr_ctrl_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned AW    = 2,
  parameter int unsigned DEPTH = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*W-1:0]  wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    ack;
  logic               err;
  logic [W-1:0]       ld;
  logic [DEPTH-1:0]   len;
  logic               busy;

  modport master (
    output req, addr, wdata,
    input  gnt, ack, err, ld, len, busy
  );

  modport slave (
    input  req, addr, wdata,
    output gnt, ack, err, ld, len, busy
  );
endinterface

// File: rtl/latch_bank_wr_ctrl.sv
// Round-robin write controller for a bank of gated-D latch words.
// Each write runs setup -> enable pulse -> hold -> done so the latch data
// is never changing while any word enable is high.
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active low
//   bus   : slave side of latch_bank_wr_ctrl_if (requests in, grants/acks,
//           latch data and latch enables out; all outputs come from flops)
module latch_bank_wr_ctrl #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned W         = 8,
  parameter int unsigned AW        = 2,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 1,
  parameter int unsigned HOLD_CYC  = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  latch_bank_wr_ctrl_if.slave  bus
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    rr_q, rr_d;
  logic [PW-1:0]    own_q, own_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             bad_q, bad_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic [W-1:0]     ld_q, ld_d;
  logic [DEPTH-1:0] len_q, len_d;

  logic             win_vld;
  logic [PW-1:0]    win_idx;
  logic [AW-1:0]    win_addr;
  logic [W-1:0]     win_data;

  // Round-robin pick: first requester at or above the pointer, with wrap.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      for (int k = 0; k < int'(NREQ); k++) begin
        if (!win_vld && bus.req[k] && (k == (int'(rr_q) + i) % int'(NREQ))) begin
          win_vld  = 1'b1;
          win_idx  = PW'(k);
          win_addr = bus.addr[k*AW +: AW];
          win_data = bus.wdata[k*W +: W];
        end
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    own_d   = own_q;
    addr_d  = addr_q;
    bad_d   = bad_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    err_d   = 1'b0;
    ld_d    = ld_q;
    len_d   = len_q;

    unique case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_SETUP;
          cnt_d   = CW'(SETUP_CYC - 1);
          own_d   = win_idx;
          addr_d  = win_addr;
          bad_d   = (32'(win_addr) >= DEPTH);
          gnt_d   = NREQ'(1) << win_idx;
          ld_d    = win_data;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = CW'(PULSE_CYC - 1);
          // Out-of-range address: run the timing but raise no enable.
          if (!bad_q) len_d = DEPTH'(1) << addr_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = CW'(HOLD_CYC - 1);
          len_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          ack_d   = gnt_q;
          err_d   = bad_q;
          gnt_d   = '0;
          ld_d    = '0;
          rr_d    = (32'(own_q) == NREQ - 1) ? '0 : own_q + PW'(1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      own_q   <= '0;
      addr_q  <= '0;
      bad_q   <= 1'b0;
      gnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ld_q    <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      own_q   <= own_d;
      addr_q  <= addr_d;
      bad_q   <= bad_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      ld_q    <= ld_d;
      len_q   <= len_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.ack  = ack_q;
  assign bus.err  = err_q;
  assign bus.busy = busy_q;
  assign bus.ld   = ld_q;
  assign bus.len  = len_q;

endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// Bench for latch_bank_wr_ctrl: two instances (default timing, and a
// short bank with stretched timing) checked every cycle against a
// transaction-schedule model, plus directed literal checks.
module tb_latch_bank_wr_ctrl;

  localparam int NR = 4;
  localparam int DEPV [2] = '{4, 3};
  localparam int SC   [2] = '{1, 2};
  localparam int PC   [2] = '{1, 3};
  localparam int HC   [2] = '{1, 2};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  latch_bank_wr_ctrl_if #(.NREQ(4), .W(8), .AW(2), .DEPTH(4)) bus0 ();
  latch_bank_wr_ctrl_if #(.NREQ(4), .W(8), .AW(2), .DEPTH(3)) bus1 ();

  latch_bank_wr_ctrl #(.NREQ(4), .W(8), .AW(2), .DEPTH(4),
    .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) u_def (.clk(clk), .rst_n(rst_n), .bus(bus0));
  latch_bank_wr_ctrl #(.NREQ(4), .W(8), .AW(2), .DEPTH(3),
    .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) u_alt (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [3:0]  m_req  [2];
  logic [7:0]  m_addr [2];
  logic [31:0] m_wd   [2];
  assign bus0.req = m_req[0];  assign bus0.addr = m_addr[0];  assign bus0.wdata = m_wd[0];
  assign bus1.req = m_req[1];  assign bus1.addr = m_addr[1];  assign bus1.wdata = m_wd[1];

  logic [3:0] d_gnt [2], d_ack [2], d_len [2];
  logic [7:0] d_ld  [2];
  logic       d_err [2], d_busy [2];
  assign d_gnt[0] = bus0.gnt;  assign d_ack[0] = bus0.ack;  assign d_len[0] = bus0.len;
  assign d_ld[0]  = bus0.ld;   assign d_err[0] = bus0.err;  assign d_busy[0] = bus0.busy;
  assign d_gnt[1] = bus1.gnt;  assign d_ack[1] = bus1.ack;  assign d_len[1] = {1'b0, bus1.len};
  assign d_ld[1]  = bus1.ld;   assign d_err[1] = bus1.err;  assign d_busy[1] = bus1.busy;

  int n_chk = 0;
  int n_fail = 0;

  // Model: t = cycles since the capture edge (0 = idle); one write lasts
  // SETUP+PULSE+HOLD+1 cycles, the last of which carries the ack.
  int         t   [2] = '{0, 0};
  int         win [2] = '{0, 0};
  int         ma  [2] = '{0, 0};
  logic [7:0] md  [2];
  int         rr  [2] = '{0, 0};
  logic [7:0] em   [2][4] = '{default: 8'h00};
  logic [7:0] bank [2][4];

  function automatic int lat(input int i);
    return SC[i] + PC[i] + HC[i] + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        // A write cut by reset leaves its word undefined: accept what the cells hold.
        if (t[i] != 0 && ma[i] < DEPV[i]) em[i][ma[i]] <= bank[i][ma[i]];
        t[i]  <= 0;
        rr[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (t[i] == 0) begin
          int w;
          w = -1;
          for (int j = 0; j < NR; j++)
            if (w < 0 && m_req[i][(rr[i] + j) % NR]) w = (rr[i] + j) % NR;
          if (w >= 0) begin
            win[i] <= w;
            ma[i]  <= int'((m_addr[i] >> (2 * w)) & 8'h03);
            md[i]  <= 8'(m_wd[i] >> (8 * w));
            t[i]   <= 1;
          end
        end else if (t[i] == lat(i)) begin
          if (ma[i] < DEPV[i]) em[i][ma[i]] <= md[i];
          rr[i] <= (win[i] + 1) % NR;
          t[i]  <= 0;
        end else begin
          t[i] <= t[i] + 1;
        end
      end
    end
  end

  function automatic logic [3:0] e_gnt(input int i);
    return (t[i] >= 1 && t[i] < lat(i)) ? 4'(1 << win[i]) : 4'h0;
  endfunction
  function automatic logic [7:0] e_ld(input int i);
    return (t[i] >= 1 && t[i] < lat(i)) ? md[i] : 8'h00;
  endfunction
  function automatic logic [3:0] e_len(input int i);
    return (t[i] > SC[i] && t[i] <= SC[i] + PC[i] && ma[i] < DEPV[i]) ? 4'(1 << ma[i]) : 4'h0;
  endfunction
  function automatic logic [3:0] e_ack(input int i);
    return (t[i] == lat(i)) ? 4'(1 << win[i]) : 4'h0;
  endfunction
  function automatic logic e_err(input int i);
    return (t[i] == lat(i)) && (ma[i] >= DEPV[i]);
  endfunction

  function automatic int oh2i(input logic [3:0] v);
    for (int j = 0; j < 4; j++) if (v[j]) return j;
    return -1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison plus a behavioural model of the latch cells.
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("u%0d.gnt", i),  32'(d_gnt[i]),  32'(e_gnt(i)));
        check($sformatf("u%0d.ld", i),   32'(d_ld[i]),   32'(e_ld(i)));
        check($sformatf("u%0d.len", i),  32'(d_len[i]),  32'(e_len(i)));
        check($sformatf("u%0d.ack", i),  32'(d_ack[i]),  32'(e_ack(i)));
        check($sformatf("u%0d.err", i),  32'(d_err[i]),  32'(e_err(i)));
        check($sformatf("u%0d.busy", i), 32'(d_busy[i]), 32'(t[i] != 0));
        for (int j = 0; j < 4; j++) if (d_len[i][j]) bank[i][j] = d_ld[i];
        if (t[i] == 0)
          for (int j = 0; j < DEPV[i]; j++)
            check($sformatf("u%0d.word%0d", i, j), 32'(bank[i][j]), 32'(em[i][j]));
      end
    end
  endtask

  task automatic wait_ack(input int i, input logic [3:0] exp, input string nm);
    logic got;
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      if (d_ack[i] != 4'h0) got = 1'b1;
    end
    check(nm, 32'(d_ack[i]), 32'(exp));
  endtask

  initial begin
    logic       found;
    logic [7:0] snap [4];
    int         order [$];
    int         exp_o [5];
    int         len_hi, ack_cyc;
    logic [3:0] a;

    exp_o = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 2; i++) begin
      m_req[i] = 4'h0; m_addr[i] = 8'h00; m_wd[i] = 32'h0;
      for (int j = 0; j < 4; j++) bank[i][j] = 8'h00;
    end
    fork compare_loop(); join_none

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.busy", 32'(d_busy[0]), 32'h0);
    check("rst.gnt",  32'(d_gnt[0]),  32'h0);
    check("rst.len",  32'(d_len[0]),  32'h0);
    check("rst.ld",   32'(d_ld[0]),   32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write: requester 1, word 2, data A5.
    m_req[0] = 4'b0010; m_addr[0] = 8'h08; m_wd[0] = 32'h0000_A500;
    @(negedge clk);
    check("t2.ld_n1", 32'(d_ld[0]), 32'hA5);
    check("t2.len_n1", 32'(d_len[0]), 32'h0);
    check("t2.gnt_n1", 32'(d_gnt[0]), 32'h2);
    @(negedge clk);
    check("t2.len_n2", 32'(d_len[0]), 32'h4);
    check("t2.model_len_n2", 32'(e_len(0)), 32'h4);
    check("t2.ld_n2", 32'(d_ld[0]), 32'hA5);
    @(negedge clk);
    check("t2.len_n3", 32'(d_len[0]), 32'h0);
    check("t2.ld_n3", 32'(d_ld[0]), 32'hA5);
    @(negedge clk);
    check("t2.ack_n4", 32'(d_ack[0]), 32'h2);
    check("t2.model_ack_n4", 32'(e_ack(0)), 32'h2);
    check("t2.err_n4", 32'(d_err[0]), 32'h0);
    m_req[0] = 4'h0;
    @(negedge clk);
    check("t2.word2", 32'(bank[0][2]), 32'hA5);
    check("t2.model_word2", 32'(em[0][2]), 32'hA5);

    // Reset in the middle of an enable pulse.
    m_req[0] = 4'b0100; m_addr[0] = 8'h10; m_wd[0] = 32'h00C3_0000;
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      @(posedge clk); #2;
      if (d_len[0] != 4'h0) found = 1'b1;
    end
    check("t1.pulse_seen", 32'(found), 32'h1);
    rst_n = 1'b0; m_req[0] = 4'h0;
    #1;
    check("t1.len_rst", 32'(d_len[0]), 32'h0);
    check("t1.gnt_rst", 32'(d_gnt[0]), 32'h0);
    check("t1.busy_rst", 32'(d_busy[0]), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_req[0] = 4'b1001; m_addr[0] = 8'h40; m_wd[0] = 32'h9600_005A;
    @(negedge clk);
    check("t1.gnt_after_rst", 32'(d_gnt[0]), 32'h1);
    wait_ack(0, 4'b0001, "t1.ack0");
    m_req[0] = 4'b1000;
    wait_ack(0, 4'b1000, "t1.ack3");
    m_req[0] = 4'h0;
    @(negedge clk);

    // All four requesting: grant order from a fresh pointer.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_req[0] = 4'hF; m_addr[0] = 8'($urandom); m_wd[0] = $urandom;
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      @(negedge clk);
      if (d_ack[0] != 4'h0) begin
        order.push_back(oh2i(d_ack[0]));
        m_wd[0] = $urandom;
        if (order.size() == 5) m_req[0] = 4'h0;
      end
    end
    m_req[0] = 4'h0;
    for (int k = 0; k < 5; k++)
      check($sformatf("t3.order%0d", k), (order.size() > k) ? order[k] : -1, exp_o[k]);
    repeat (2) @(negedge clk);

    // Short bank: write to word 3 does not exist.
    for (int j = 0; j < 4; j++) snap[j] = bank[1][j];
    m_req[1] = 4'b0001; m_addr[1] = 8'h03; m_wd[1] = 32'h0000_005A;
    len_hi = 0; found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (d_len[1] != 4'h0) len_hi++;
      if (d_ack[1] != 4'h0) begin
        found = 1'b1;
        check("t4.ack", 32'(d_ack[1]), 32'h1);
        check("t4.err", 32'(d_err[1]), 32'h1);
        m_req[1] = 4'h0;
      end
    end
    check("t4.ack_seen", 32'(found), 32'h1);
    check("t4.len_cycles", 32'(len_hi), 32'h0);
    @(negedge clk);
    for (int j = 0; j < 3; j++) check($sformatf("t4.word%0d", j), 32'(bank[1][j]), 32'(snap[j]));

    // Stretched timing: 3-cycle pulse, ack 8 cycles after capture, late data ignored.
    m_req[1] = 4'b0010; m_addr[1] = 8'h04; m_wd[1] = 32'h0000_3C00;
    len_hi = 0; ack_cyc = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c < 8) check($sformatf("t5.ld_c%0d", c), 32'(d_ld[1]), 32'h3C);
      if (c == 2) m_wd[1] = 32'h0000_FF00;
      if (d_len[1] != 4'h0) len_hi++;
      if (d_ack[1] != 4'h0 && ack_cyc == 0) begin
        ack_cyc = c;
        m_req[1] = 4'h0;
      end
    end
    check("t5.len_cycles", 32'(len_hi), 32'h3);
    check("t5.ack_cycle", 32'(ack_cyc), 32'h8);
    check("t5.word1", 32'(bank[1][1]), 32'h3C);

    // Requester 3 drops its request right after capture.
    m_req[0] = 4'b1000; m_addr[0] = 8'h80; m_wd[0] = 32'h7E00_0000;
    @(negedge clk);
    check("t6.gnt", 32'(d_gnt[0]), 32'h8);
    m_req[0] = 4'h0;
    wait_ack(0, 4'b1000, "t6.ack");
    @(negedge clk);
    check("t6.word2", 32'(bank[0][2]), 32'h7E);

    // Random traffic on both instances, obeying the hold-until-ack protocol.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        a = e_ack(i);
        for (int k = 0; k < 4; k++) begin
          if (a[k]) begin
            if ($urandom_range(1) == 0) m_req[i][k] = 1'b0;
            else begin
              m_addr[i][2*k +: 2] = 2'($urandom);
              m_wd[i][8*k +: 8]   = 8'($urandom);
            end
          end else if (!m_req[i][k] && $urandom_range(3) == 0) begin
            m_req[i][k]         = 1'b1;
            m_addr[i][2*k +: 2] = 2'($urandom);
            m_wd[i][8*k +: 8]   = 8'($urandom);
          end else if (t[i] > 0 && t[i] < lat(i) && win[i] == k && $urandom_range(3) == 0) begin
            m_wd[i][8*k +: 8]   = 8'($urandom);
          end
        end
      end
    end

    m_req[0] = 4'h0; m_req[1] = 4'h0;
    repeat (12) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
